down_counter: RTL and testbench



---
 rtl/down_counter.sv | 30 +++
 tb/tb_down_counter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// Free-running down counter with reload-on-zero, terminal-count decode and a
// registered wrap pulse; usable as a periodic tick source.
module down_counter #(
    parameter int unsigned          WIDTH  = 4,
    parameter logic [WIDTH-1:0]     RELOAD = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             wrap
);

    assign zero = (count == '0);

    // Zero reloads explicitly rather than borrowing, so any RELOAD sets the period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= RELOAD;
            wrap  <= 1'b0;
        end else if (zero) begin
            count <= RELOAD;
            wrap  <= 1'b1;
        end else begin
            count <= count - WIDTH'(1);
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter: default width, a 3-bit/RELOAD=5 variant and
// a degenerate RELOAD=0 variant, each with its own reset.
module tb_down_counter;

    logic       clk;
    logic       rst_a, rst_b, rst_c;
    logic [3:0] cnt_a;
    logic       zero_a, wrap_a;
    logic [2:0] cnt_b;
    logic       zero_b, wrap_b;
    logic [3:0] cnt_c;
    logic       zero_c, wrap_c;

    int checks   = 0;
    int failures = 0;

    down_counter dut_a (.clk(clk), .reset(rst_a), .count(cnt_a), .zero(zero_a), .wrap(wrap_a));
    down_counter #(.WIDTH(3), .RELOAD(3'd5)) dut_b (.clk(clk), .reset(rst_b), .count(cnt_b), .zero(zero_b), .wrap(wrap_b));
    down_counter #(.WIDTH(4), .RELOAD(4'd0)) dut_c (.clk(clk), .reset(rst_c), .count(cnt_c), .zero(zero_c), .wrap(wrap_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic [3:0] cnt;
        logic       zr;
        logic       wr;
    } vec_t;

    vec_t vecs [19];
    int   seq_b [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_a(input string name, input logic [3:0] c, input logic z, input logic w);
        chk({name, ".count"}, 32'(cnt_a), 32'(c));
        chk({name, ".zero"}, 32'(zero_a), 32'(z));
        chk({name, ".wrap"}, 32'(wrap_a), 32'(w));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 4'hF, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'hF, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'hE, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'hD, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'hC, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'hB, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'hA, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'h9, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 4'h8, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'h7, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 4'h6, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 4'h5, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 4'h4, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 4'h3, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 4'h2, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 4'h1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 4'h0, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 4'hF, 1'b0, 1'b1};
        vecs[18] = '{1'b1, 4'hE, 1'b0, 1'b0};
        seq_b = '{4, 3, 2, 1, 0, 5, 4, 3, 2, 1, 0, 5, 4};

        // Assert all resets before the first clock edge and check immediately.
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        #2;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        #1;
        chk_a("pre_edge_reset", 4'hF, 1'b0, 1'b0);
        chk("pre_edge_b.count", 32'(cnt_b), 32'd5);
        chk("pre_edge_c.count", 32'(cnt_c), 32'd0);
        chk("pre_edge_c.zero", 32'(zero_c), 32'd1);
        chk("pre_edge_c.wrap", 32'(wrap_c), 32'd0);

        // Reset hold, release, count down through terminal count and wrap.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rst_a = vecs[i].rst;
            @(posedge clk);
            #1;
            chk_a($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].zr, vecs[i].wr);
        end

        // Asynchronous reset mid-count at 7.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
        end
        chk_a("reach_7", 4'h7, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_a = 1'b0;
        #1;
        chk_a("async_mid", 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        chk_a("resume", 4'hE, 1'b0, 1'b0);

        // Run to the next wrap, then reset while the wrap pulse is in flight.
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
        end
        chk_a("second_zero", 4'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk_a("second_wrap", 4'hF, 1'b0, 1'b1);
        #2;
        rst_a = 1'b0;
        #1;
        chk_a("wrap_cleared", 4'hF, 1'b0, 1'b0);

        // WIDTH=3, RELOAD=5 variant.
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b%0d.count", i), 32'(cnt_b), 32'(seq_b[i]));
            chk($sformatf("b%0d.zero", i), 32'(zero_b), 32'(seq_b[i] == 0));
            chk($sformatf("b%0d.wrap", i), 32'(wrap_b), 32'(i == 5 || i == 11));
        end

        // RELOAD=0 variant: stuck at zero, wrapping every edge.
        @(negedge clk);
        rst_c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("c%0d.count", i), 32'(cnt_c), 32'd0);
            chk($sformatf("c%0d.zero", i), 32'(zero_c), 32'd1);
            chk($sformatf("c%0d.wrap", i), 32'(wrap_c), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
